// File: rtl/dram_ring_pkg.sv
// Shared types and constants for the DRAM ring buffer blocks:
// the port arbiter, the read controller and the stream writer.
package dram_ring_pkg;

  localparam int ADDR_W = 25;
  localparam int WAIT_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  // Ring addresses wrap naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Request/ack handshakes of writer and reader plus the DRAM command port.
// The master modport is the arbiter's view; slave is the clients/controller view.
interface dram_port_arbiter_if;
  import dram_ring_pkg::*;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_blocked;
  logic [WAIT_W-1:0] max_wait;
  logic              cmd_valid;
  logic              cmd_rnw;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ready;
  logic [ADDR_W-1:0] wr_head;
  logic [1:0]        state;

  modport master (
    input  wr_req, wr_addr, rd_req, rd_addr, max_wait, cmd_ready,
    output wr_ack, rd_ack, rd_blocked, cmd_valid, cmd_rnw, cmd_addr, wr_head, state
  );

  modport slave (
    output wr_req, wr_addr, rd_req, rd_addr, max_wait, cmd_ready,
    input  wr_ack, rd_ack, rd_blocked, cmd_valid, cmd_rnw, cmd_addr, wr_head, state
  );

endinterface

// File: rtl/dram_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter import dram_ring_pkg::*; #(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Arbitrates the single DRAM command port between ring writer and reader.
// Writes win unless the reader has been starved for more than max_wait cycles.
//
//   state | meaning
//   IDLE  | no command outstanding; grant decision made here
//   WR    | write command presented, waiting for cmd_ready
//   RD    | read command presented, waiting for cmd_ready
module dram_port_arbiter import dram_ring_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  dram_port_arbiter_if.master bus
);

  logic [1:0]        state_q;
  cmd_t              cmd_q;
  logic              cmd_valid_q;
  logic              wr_ack_q;
  logic              rd_ack_q;
  logic [ADDR_W-1:0] wr_head_q;
  logic [WAIT_W-1:0] starve_cnt;

  logic rd_blocked;
  logic rd_elig;
  logic wr_elig;
  logic starved;
  logic go_rd;
  logic go_wr;
  logic hs;

  // A requester acked last cycle has not yet had a chance to drop its request.
  assign rd_blocked = bus.rd_req && (bus.rd_addr == wr_head_q);
  assign rd_elig    = bus.rd_req && !rd_blocked && !rd_ack_q;
  assign wr_elig    = bus.wr_req && !wr_ack_q;
  assign starved    = starve_cnt > bus.max_wait;
  assign go_rd      = (state_q == IDLE) && rd_elig && (starved || !wr_elig);
  assign go_wr      = (state_q == IDLE) && !go_rd && wr_elig;
  assign hs         = cmd_valid_q && bus.cmd_ready;

  sat_counter #(.W(WAIT_W)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (rd_elig && (state_q != RD)),
    .clr (go_rd),
    .cnt (starve_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      wr_head_q   <= '0;
    end else begin
      wr_ack_q <= hs && !cmd_q.rnw;
      rd_ack_q <= hs && cmd_q.rnw;
      case (state_q)
        IDLE: begin
          if (go_rd) begin
            state_q     <= RD;
            cmd_q       <= '{rnw: 1'b1, addr: bus.rd_addr};
            cmd_valid_q <= 1'b1;
          end else if (go_wr) begin
            state_q     <= WR;
            cmd_q       <= '{rnw: 1'b0, addr: bus.wr_addr};
            cmd_valid_q <= 1'b1;
          end
        end
        WR, RD: begin
          if (bus.cmd_ready) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            if (state_q == WR) begin
              wr_head_q <= addr_next(cmd_q.addr);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ack     = wr_ack_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_blocked = rd_blocked;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_rnw    = cmd_q.rnw;
  assign bus.cmd_addr   = cmd_q.addr;
  assign bus.wr_head    = wr_head_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench: stimulus queues expected DRAM commands and directed checks;
// a negedge monitor pops and compares them as the arbiter presents results.
module tb_dram_port_arbiter;
  import dram_ring_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dram_port_arbiter_if bus();

  dram_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] e;
  } chk_t;

  chk_t dq[$];
  cmd_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic pend_w   = 1'b0;
  logic pend_r   = 1'b0;
  chk_t mc;
  cmd_t got;
  cmd_t want;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
    dq.push_back('{name: name, act: act, e: e});
  endtask

  always @(negedge clk) begin
    while (dq.size() > 0) begin
      mc = dq.pop_front();
      checks++;
      if (mc.act !== mc.e) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", mc.name, mc.act, mc.e);
      end
    end
    if (rst) begin
      pend_w = 1'b0;
      pend_r = 1'b0;
    end else begin
      if (pend_w || pend_r || bus.wr_ack || bus.rd_ack) begin
        checks++;
        if ({bus.wr_ack, bus.rd_ack} !== {pend_w, pend_r}) begin
          failures++;
          $display("FAIL ack_pulse: got wr/rd=%b%b expected %b%b",
                   bus.wr_ack, bus.rd_ack, pend_w, pend_r);
        end
      end
      pend_w = 1'b0;
      pend_r = 1'b0;
      if (bus.cmd_valid && bus.cmd_ready) begin
        got = '{rnw: bus.cmd_rnw, addr: bus.cmd_addr};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_cmd: got rnw=%0d addr=0x%0h expected none", got.rnw, got.addr);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL cmd: got rnw=%0d addr=0x%0h expected rnw=%0d addr=0x%0h",
                     got.rnw, got.addr, want.rnw, want.addr);
          end
        end
        pend_w = !bus.cmd_rnw;
        pend_r = bus.cmd_rnw;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit rd, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (rd ? bus.rd_ack : bus.wr_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a);
    bit ok;
    exp_q.push_back('{rnw: 1'b0, addr: a});
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    wait_ack(1'b0, ok);
    chk("wr_ack_timeout", 32'(ok), 1);
    bus.wr_req = 1'b0;
    tick();
  endtask

  // Read parked on wr_head until the writer passes it.
  task automatic blocked_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] head_after);
    bit ok;
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    repeat (3) begin
      tick();
      chk("blk_rd_blocked", 32'(bus.rd_blocked), 1);
      chk("blk_no_cmd", 32'(bus.cmd_valid), 0);
    end
    exp_q.push_back('{rnw: 1'b0, addr: a});
    exp_q.push_back('{rnw: 1'b1, addr: a});
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    wait_ack(1'b0, ok);
    chk("blk_wr_ack_timeout", 32'(ok), 1);
    chk("blk_wr_head", 32'(bus.wr_head), 32'(head_after));
    chk("blk_unblocked", 32'(bus.rd_blocked), 0);
    bus.wr_req = 1'b0;
    wait_ack(1'b1, ok);
    chk("blk_rd_ack_timeout", 32'(ok), 1);
    bus.rd_req = 1'b0;
    tick();
    chk("rd_ack_one_cycle", 32'(bus.rd_ack), 0);
  endtask

  task automatic stall_write(input logic [ADDR_W-1:0] a);
    bit ok;
    int n_ack;
    bus.cmd_ready = 1'b0;
    exp_q.push_back('{rnw: 1'b0, addr: a});
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    tick();
    repeat (5) begin
      chk("stall_valid", 32'(bus.cmd_valid), 1);
      chk("stall_addr", 32'(bus.cmd_addr), 32'(a));
      chk("stall_rnw", 32'(bus.cmd_rnw), 0);
      chk("stall_no_ack", 32'(bus.wr_ack), 0);
      tick();
    end
    bus.cmd_ready = 1'b1;
    wait_ack(1'b0, ok);
    chk("stall_ack_timeout", 32'(ok), 1);
    chk("stall_wr_head", 32'(bus.wr_head), 32'(a) + 1);
    bus.wr_req = 1'b0;
    n_ack = 0;
    repeat (4) begin
      tick();
      if (bus.wr_ack) n_ack++;
    end
    chk("stall_single_ack", 32'(n_ack), 0);
  endtask

  // Reader waits through a stalled write, then both requesters arrive together.
  task automatic starve_case(input logic [WAIT_W-1:0] mw, input logic [ADDR_W-1:0] wa1,
                             input logic [ADDR_W-1:0] wa2, input logic [ADDR_W-1:0] ra,
                             input bit rd_first);
    bit ok;
    bit got_w;
    bit got_r;
    bus.max_wait  = mw;
    bus.cmd_ready = 1'b0;
    exp_q.push_back('{rnw: 1'b0, addr: wa1});
    if (rd_first) begin
      exp_q.push_back('{rnw: 1'b1, addr: ra});
      exp_q.push_back('{rnw: 1'b0, addr: wa2});
    end else begin
      exp_q.push_back('{rnw: 1'b0, addr: wa2});
      exp_q.push_back('{rnw: 1'b1, addr: ra});
    end
    bus.wr_req  = 1'b1;
    bus.wr_addr = wa1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = ra;
    repeat (6) tick();
    chk("starve_first_is_write", 32'(bus.cmd_rnw), 0);
    chk("starve_stall_valid", 32'(bus.cmd_valid), 1);
    bus.rd_req    = 1'b0;
    bus.cmd_ready = 1'b1;
    wait_ack(1'b0, ok);
    chk("starve_wr_ack_timeout", 32'(ok), 1);
    bus.wr_req = 1'b0;
    tick();
    chk("starve_idle", 32'(bus.state), 32'(IDLE));
    bus.wr_req  = 1'b1;
    bus.wr_addr = wa2;
    bus.rd_req  = 1'b1;
    tick();
    chk("starve_winner_rnw", 32'(bus.cmd_rnw), 32'(rd_first));
    chk("starve_winner_state", 32'(bus.state), rd_first ? 32'(RD) : 32'(WR));
    got_w = 1'b0;
    got_r = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bus.wr_ack) begin
        bus.wr_req = 1'b0;
        got_w = 1'b1;
      end
      if (bus.rd_ack) begin
        bus.rd_req = 1'b0;
        got_r = 1'b1;
      end
      if (got_w && got_r) break;
    end
    chk("starve_both_acks", 32'({got_w, got_r}), 3);
    tick();
  endtask

  initial begin
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    bus.max_wait  = 8'd255;
    bus.cmd_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (3) tick();
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rst_cmd_rnw", 32'(bus.cmd_rnw), 0);
    chk("rst_cmd_addr", 32'(bus.cmd_addr), 0);
    chk("rst_wr_head", 32'(bus.wr_head), 0);
    chk("rst_acks", 32'({bus.wr_ack, bus.rd_ack}), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_ready_ignored", 32'({bus.cmd_valid, bus.wr_ack, bus.rd_ack}), 0);

    // Single write: one-cycle request-to-valid, ack in following cycle.
    exp_q.push_back('{rnw: 1'b0, addr: 25'h10});
    bus.wr_req  = 1'b1;
    bus.wr_addr = 25'h10;
    tick();
    chk("t1_valid", 32'(bus.cmd_valid), 1);
    chk("t1_rnw", 32'(bus.cmd_rnw), 0);
    chk("t1_addr", 32'(bus.cmd_addr), 32'h10);
    chk("t1_state", 32'(bus.state), 32'(WR));
    tick();
    chk("t1_wr_ack", 32'(bus.wr_ack), 1);
    chk("t1_wr_head", 32'(bus.wr_head), 32'h11);
    chk("t1_valid_drop", 32'(bus.cmd_valid), 0);
    bus.wr_req = 1'b0;
    tick();
    chk("t1_ack_one_cycle", 32'(bus.wr_ack), 0);

    blocked_read(25'h11, 25'h12);
    stall_write(25'h30);
    starve_case(8'd3, 25'h50, 25'h52, 25'h60, 1'b1);
    starve_case(8'd255, 25'h70, 25'h72, 25'h60, 1'b0);

    do_write(25'h1FFFFFE);
    blocked_read(25'h1FFFFFF, 25'h0);

    // Reset while a write waits on cmd_ready.
    bus.cmd_ready = 1'b0;
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 25'h99;
    tick();
    tick();
    chk("pre_rst_valid", 32'(bus.cmd_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(bus.cmd_valid), 0);
    chk("rst_async_state", 32'(bus.state), 32'(IDLE));
    chk("rst_async_wr_head", 32'(bus.wr_head), 0);
    bus.wr_req    = 1'b0;
    bus.cmd_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_no_ack", 32'({bus.wr_ack, bus.rd_ack}), 0);
    end
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", 32'(bus.cmd_valid), 0);

    chk("exp_queue_empty", 32'(exp_q.size()), 0);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
